// File: rtl/minisrc_ctrl_pkg.sv
// Shared constants and types for the Mini SRC control sequencer:
// opcodes, ALU operation codes, FSM states, fault codes and opcode decode helpers.
package minisrc_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [3:0] ALU_AND  = 4'h0;
  localparam logic [3:0] ALU_OR   = 4'h1;
  localparam logic [3:0] ALU_ADD  = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h3;
  localparam logic [3:0] ALU_MUL  = 4'h4;
  localparam logic [3:0] ALU_DIV  = 4'h6;
  localparam logic [3:0] ALU_SHR  = 4'h7;
  localparam logic [3:0] ALU_SHRA = 4'h8;
  localparam logic [3:0] ALU_SHL  = 4'h9;
  localparam logic [3:0] ALU_ROR  = 4'hA;
  localparam logic [3:0] ALU_ROL  = 4'hB;
  localparam logic [3:0] ALU_NEG  = 4'hC;
  localparam logic [3:0] ALU_NOT  = 4'hD;

  typedef enum logic [3:0] {
    S_RST, S_F0, S_F1, S_F2, S_E3, S_E4, S_E5, S_E6, S_HALT
  } state_t;

  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_TIMEOUT = 2'b10
  } fault_t;

  typedef enum logic [2:0] {
    CLS_RFMT, CLS_UNARY, CLS_MULDIV, CLS_NOP, CLS_HALT, CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:      return CLS_RFMT;
      OP_NEG, OP_NOT:                       return CLS_UNARY;
      OP_MUL, OP_DIV:                       return CLS_MULDIV;
      OP_NOP:                               return CLS_NOP;
      OP_HALT:                              return CLS_HALT;
      default:                              return CLS_ILLEGAL;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_ROR:  return ALU_ROR;
      OP_ROL:  return ALU_ROL;
      OP_SHR:  return ALU_SHR;
      OP_SHRA: return ALU_SHRA;
      OP_SHL:  return ALU_SHL;
      OP_MUL:  return ALU_MUL;
      OP_DIV:  return ALU_DIV;
      OP_NEG:  return ALU_NEG;
      OP_NOT:  return ALU_NOT;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_encode.sv
// Turns the Gra/Grb/Grc field selection into one-hot general register
// load (R_in) and bus-drive (R_out) enables. Purely combinational.
module reg_select_encode
  import minisrc_ctrl_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic [31:0]         i_ir,
  input  logic                i_gra,
  input  logic                i_grb,
  input  logic                i_grc,
  input  logic                i_rin,
  input  logic                i_rout,
  output logic [NUM_REGS-1:0] o_r_in,
  output logic [NUM_REGS-1:0] o_r_out
);

  logic [3:0]          w_sel;
  logic                w_any;
  logic [NUM_REGS-1:0] w_onehot;
  logic                w_unused_ir;

  assign w_unused_ir = ^{i_ir[31:27], i_ir[14:0]};
  assign w_any       = i_gra | i_grb | i_grc;

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    w_sel = 4'd0;
    if (i_gra)      w_sel = i_ir[26:23];
    else if (i_grb) w_sel = i_ir[22:19];
    else if (i_grc) w_sel = i_ir[18:15];
  end

  // A field value beyond NUM_REGS-1 selects no register at all.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_onehot[i] = w_any && (i == int'(w_sel));
    end
  end

  assign o_r_in  = i_rin  ? w_onehot : '0;
  assign o_r_out = i_rout ? w_onehot : '0;

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit for the Mini SRC datapath: fetch with memory handshake and
// read timeout, decode, and execute sequencing for ALU, unary, mul/div, nop and halt.
module control_sequencer
  import minisrc_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 16,
  parameter int READ_TIMEOUT = 255
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic [31:0]         i_ir,
  input  logic                i_mem_ready,
  input  logic                i_stop,
  output logic                o_pcout,
  output logic                o_zlowout,
  output logic                o_zhighout,
  output logic                o_mdrout,
  output logic                o_marin,
  output logic                o_zin,
  output logic                o_pcin,
  output logic                o_mdrin,
  output logic                o_irin,
  output logic                o_yin,
  output logic                o_hiin,
  output logic                o_loin,
  output logic                o_incpc,
  output logic                o_read,
  output logic [3:0]          o_alu_sel,
  output logic [NUM_REGS-1:0] o_r_in,
  output logic [NUM_REGS-1:0] o_r_out,
  output logic                o_run,
  output logic [1:0]          o_fault_code
);

  localparam int              CNT_W       = (READ_TIMEOUT > 0) ? $clog2(READ_TIMEOUT + 1) : 1;
  localparam logic [CNT_W:0]  TIMEOUT_VAL = (CNT_W + 1)'(READ_TIMEOUT);

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_wait_cnt, w_next_cnt;
  fault_t           r_fault, w_next_fault;
  logic             r_stop_pend, w_next_stop;

  logic [4:0]       w_opcode;
  op_class_t        w_cls;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_stop_req;
  logic             w_first_f1;
  logic             w_gra, w_grb, w_grc, w_rin, w_rout;

  assign w_opcode   = i_ir[31:27];
  assign w_cls      = classify(w_opcode);
  assign w_cnt_inc  = {1'b0, r_wait_cnt} + 1'b1;
  assign w_stop_req = r_stop_pend | i_stop;
  // The stall counter saturates, so it is zero only on the first F1 cycle.
  assign w_first_f1 = (r_wait_cnt == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= S_RST;
      r_wait_cnt  <= '0;
      r_fault     <= FAULT_NONE;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_wait_cnt  <= w_next_cnt;
      r_fault     <= w_next_fault;
      r_stop_pend <= w_next_stop;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_wait_cnt;
    w_next_fault = r_fault;
    w_next_stop  = w_stop_req;
    case (r_state)
      S_RST: begin
        w_next_state = S_F0;
        w_next_stop  = 1'b0;
      end
      S_F0: begin
        w_next_state = S_F1;
        w_next_cnt   = '0;
      end
      S_F1: begin
        if (i_mem_ready) begin
          w_next_state = S_F2;
        end else begin
          if (!w_cnt_inc[CNT_W]) w_next_cnt = w_cnt_inc[CNT_W-1:0];
          if (READ_TIMEOUT != 0 && w_cnt_inc == TIMEOUT_VAL) begin
            w_next_state = S_HALT;
            w_next_fault = FAULT_TIMEOUT;
          end
        end
      end
      S_F2: w_next_state = S_E3;
      S_E3: begin
        case (w_cls)
          CLS_RFMT, CLS_UNARY, CLS_MULDIV: w_next_state = S_E4;
          CLS_NOP: begin
            w_next_state = w_stop_req ? S_HALT : S_F0;
            w_next_stop  = 1'b0;
          end
          CLS_HALT: w_next_state = S_HALT;
          default: begin
            w_next_state = S_HALT;
            w_next_fault = FAULT_ILLEGAL;
          end
        endcase
      end
      S_E4: begin
        if (w_cls == CLS_RFMT || w_cls == CLS_MULDIV) begin
          w_next_state = S_E5;
        end else begin
          w_next_state = w_stop_req ? S_HALT : S_F0;
          w_next_stop  = 1'b0;
        end
      end
      S_E5: begin
        if (w_cls == CLS_MULDIV) begin
          w_next_state = S_E6;
        end else begin
          w_next_state = w_stop_req ? S_HALT : S_F0;
          w_next_stop  = 1'b0;
        end
      end
      S_E6: begin
        w_next_state = w_stop_req ? S_HALT : S_F0;
        w_next_stop  = 1'b0;
      end
      default: w_next_state = S_HALT;
    endcase
  end

  always_comb begin
    o_pcout    = 1'b0;
    o_zlowout  = 1'b0;
    o_zhighout = 1'b0;
    o_mdrout   = 1'b0;
    o_marin    = 1'b0;
    o_zin      = 1'b0;
    o_pcin     = 1'b0;
    o_mdrin    = 1'b0;
    o_irin     = 1'b0;
    o_yin      = 1'b0;
    o_hiin     = 1'b0;
    o_loin     = 1'b0;
    o_incpc    = 1'b0;
    o_read     = 1'b0;
    o_alu_sel  = ALU_AND;
    w_gra      = 1'b0;
    w_grb      = 1'b0;
    w_grc      = 1'b0;
    w_rin      = 1'b0;
    w_rout     = 1'b0;
    case (r_state)
      S_F0: begin
        o_pcout = 1'b1;
        o_marin = 1'b1;
        o_incpc = 1'b1;
        o_zin   = 1'b1;
      end
      S_F1: begin
        o_zlowout = 1'b1;
        o_pcin    = w_first_f1;
        o_read    = 1'b1;
        o_mdrin   = 1'b1;
      end
      S_F2: begin
        o_mdrout = 1'b1;
        o_irin   = 1'b1;
      end
      S_E3: begin
        case (w_cls)
          CLS_RFMT:   begin w_grb = 1'b1; w_rout = 1'b1; o_yin = 1'b1; end
          CLS_UNARY:  begin w_grb = 1'b1; w_rout = 1'b1; o_zin = 1'b1; o_alu_sel = alu_code(w_opcode); end
          CLS_MULDIV: begin w_gra = 1'b1; w_rout = 1'b1; o_yin = 1'b1; end
          default: ;
        endcase
      end
      S_E4: begin
        case (w_cls)
          CLS_RFMT:   begin w_grc = 1'b1; w_rout = 1'b1; o_zin = 1'b1; o_alu_sel = alu_code(w_opcode); end
          CLS_UNARY:  begin o_zlowout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
          CLS_MULDIV: begin w_grb = 1'b1; w_rout = 1'b1; o_zin = 1'b1; o_alu_sel = alu_code(w_opcode); end
          default: ;
        endcase
      end
      S_E5: begin
        case (w_cls)
          CLS_RFMT:   begin o_zlowout = 1'b1; w_gra = 1'b1; w_rin = 1'b1; end
          CLS_MULDIV: begin o_zlowout = 1'b1; o_loin = 1'b1; end
          default: ;
        endcase
      end
      S_E6: begin
        if (w_cls == CLS_MULDIV) begin
          o_zhighout = 1'b1;
          o_hiin     = 1'b1;
        end
      end
      default: ;
    endcase
  end

  reg_select_encode #(
    .NUM_REGS (NUM_REGS)
  ) u_reg_select (
    .i_ir    (i_ir),
    .i_gra   (w_gra),
    .i_grb   (w_grb),
    .i_grc   (w_grc),
    .i_rin   (w_rin),
    .i_rout  (w_rout),
    .o_r_in  (o_r_in),
    .o_r_out (o_r_out)
  );

  assign o_run        = (r_state != S_RST) && (r_state != S_HALT);
  assign o_fault_code = r_fault;

endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-table bench for control_sequencer: a default instance plus one with a
// short read timeout, both compared against hand-derived per-cycle strobes.
module tb_control_sequencer;

  typedef struct packed {
    logic        pcout, zlowout, zhighout, mdrout, marin, zin, pcin;
    logic        mdrin, irin, yin, hiin, loin, incpc, read;
    logic [3:0]  alu;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        run;
    logic [1:0]  fault;
  } out_t;

  typedef struct {
    string       tag;
    logic [31:0] ir;
    logic        mr;
    logic        stop;
    bit          rst_before;
    bit          chk_to;
    out_t        exp;
    out_t        exp_to;
  } vec_t;

  typedef struct {
    string tag;
    bit    to;
    out_t  exp;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ir;
  logic        mr, stop;

  logic        m_pcout, m_zlowout, m_zhighout, m_mdrout, m_marin, m_zin, m_pcin;
  logic        m_mdrin, m_irin, m_yin, m_hiin, m_loin, m_incpc, m_read, m_run;
  logic [3:0]  m_alu;
  logic [15:0] m_r_in, m_r_out;
  logic [1:0]  m_fault;

  logic        t_pcout, t_zlowout, t_zhighout, t_mdrout, t_marin, t_zin, t_pcin;
  logic        t_mdrin, t_irin, t_yin, t_hiin, t_loin, t_incpc, t_read, t_run;
  logic [3:0]  t_alu;
  logic [15:0] t_r_in, t_r_out;
  logic [1:0]  t_fault;

  out_t got_m, got_t;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  assign got_m = {m_pcout, m_zlowout, m_zhighout, m_mdrout, m_marin, m_zin, m_pcin,
                  m_mdrin, m_irin, m_yin, m_hiin, m_loin, m_incpc, m_read,
                  m_alu, m_r_in, m_r_out, m_run, m_fault};
  assign got_t = {t_pcout, t_zlowout, t_zhighout, t_mdrout, t_marin, t_zin, t_pcin,
                  t_mdrin, t_irin, t_yin, t_hiin, t_loin, t_incpc, t_read,
                  t_alu, t_r_in, t_r_out, t_run, t_fault};

  control_sequencer u_dut (
    .i_clock(clk), .i_reset(rst), .i_ir(ir), .i_mem_ready(mr), .i_stop(stop),
    .o_pcout(m_pcout), .o_zlowout(m_zlowout), .o_zhighout(m_zhighout), .o_mdrout(m_mdrout),
    .o_marin(m_marin), .o_zin(m_zin), .o_pcin(m_pcin), .o_mdrin(m_mdrin), .o_irin(m_irin),
    .o_yin(m_yin), .o_hiin(m_hiin), .o_loin(m_loin), .o_incpc(m_incpc), .o_read(m_read),
    .o_alu_sel(m_alu), .o_r_in(m_r_in), .o_r_out(m_r_out), .o_run(m_run), .o_fault_code(m_fault)
  );

  control_sequencer #(.NUM_REGS(16), .READ_TIMEOUT(2)) u_to (
    .i_clock(clk), .i_reset(rst), .i_ir(ir), .i_mem_ready(mr), .i_stop(stop),
    .o_pcout(t_pcout), .o_zlowout(t_zlowout), .o_zhighout(t_zhighout), .o_mdrout(t_mdrout),
    .o_marin(t_marin), .o_zin(t_zin), .o_pcin(t_pcin), .o_mdrin(t_mdrin), .o_irin(t_irin),
    .o_yin(t_yin), .o_hiin(t_hiin), .o_loin(t_loin), .o_incpc(t_incpc), .o_read(t_read),
    .o_alu_sel(t_alu), .o_r_in(t_r_in), .o_r_out(t_r_out), .o_run(t_run), .o_fault_code(t_fault)
  );

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic out_t e_zero();
    out_t o = '0;
    return o;
  endfunction

  function automatic out_t e_run();
    out_t o = '0;
    o.run = 1'b1;
    return o;
  endfunction

  function automatic out_t e_halt(input logic [1:0] f);
    out_t o = '0;
    o.fault = f;
    return o;
  endfunction

  function automatic out_t e_f0();
    out_t o = e_run();
    o.pcout = 1'b1; o.marin = 1'b1; o.incpc = 1'b1; o.zin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_f1(input bit pcin);
    out_t o = e_run();
    o.zlowout = 1'b1; o.pcin = pcin; o.read = 1'b1; o.mdrin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_f2();
    out_t o = e_run();
    o.mdrout = 1'b1; o.irin = 1'b1;
    return o;
  endfunction

  // Register r drives the bus, optionally loading Y or Z (with ALU op).
  function automatic out_t e_rout(input int r, input bit yin, input logic [3:0] alu, input bit zin);
    out_t o = e_run();
    o.r_out = 16'h0001 << r; o.yin = yin; o.zin = zin; o.alu = alu;
    return o;
  endfunction

  function automatic out_t e_wb(input int r);
    out_t o = e_run();
    o.zlowout = 1'b1; o.r_in = 16'h0001 << r;
    return o;
  endfunction

  function automatic out_t e_lo();
    out_t o = e_run();
    o.zlowout = 1'b1; o.loin = 1'b1;
    return o;
  endfunction

  function automatic out_t e_hi();
    out_t o = e_run();
    o.zhighout = 1'b1; o.hiin = 1'b1;
    return o;
  endfunction

  task automatic add_v(input string tag, input logic [31:0] ir_v, input out_t exp,
                       input bit mr_v = 1'b1, input bit stop_v = 1'b0, input bit rst_v = 1'b0,
                       input bit to_v = 1'b0, input out_t exp_to = '0);
    vec_t v;
    v.tag = tag; v.ir = ir_v; v.mr = mr_v; v.stop = stop_v;
    v.rst_before = rst_v; v.chk_to = to_v; v.exp = exp; v.exp_to = exp_to;
    tbl.push_back(v);
  endtask

  task automatic add_fetch(input string tag, input logic [31:0] ir_v);
    add_v({tag, "_f0"}, ir_v, e_f0());
    add_v({tag, "_f1"}, ir_v, e_f1(1'b1));
    add_v({tag, "_f2"}, ir_v, e_f2());
  endtask

  task automatic check(input string tag, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (alu %h/%h r_in %h/%h r_out %h/%h fault %b/%b)",
               tag, got, exp, got.alu, exp.alu, got.r_in, exp.r_in,
               got.r_out, exp.r_out, got.fault, exp.fault);
    end
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, e.to ? got_t : got_m, e.exp);
    end
  endtask

  task automatic check_now(input string tag, input out_t exp);
    sb_t e;
    e.tag = tag; e.to = 1'b0; e.exp = exp;
    sbq.push_back(e);
    drain();
  endtask

  task automatic bus_check(input string tag);
    int drivers;
    drivers = $countones({m_pcout, m_zlowout, m_zhighout, m_mdrout, m_r_out});
    n_cmp++;
    if (drivers > 1) begin
      n_bad++;
      $display("FAIL %s_bus: got %0d bus drivers required at most 1", tag, drivers);
    end
  endtask

  // Starts and ends on a falling edge, leaving the DUT in RST with reset released.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_now({tag, "_in_reset"}, e_zero());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input vec_t v);
    sb_t e;
    if (v.rst_before) do_reset(v.tag);
    ir = v.ir; mr = v.mr; stop = v.stop;
    e.tag = v.tag; e.to = 1'b0; e.exp = v.exp;
    sbq.push_back(e);
    if (v.chk_to) begin
      e.tag = {v.tag, "_to"}; e.to = 1'b1; e.exp = v.exp_to;
      sbq.push_back(e);
    end
    #1;
    drain();
    bus_check(v.tag);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] add_i, neg_i, mul_i, div_i, sub_i, shra_i, not_i, nop_i, ill_i, hlt_i;
    rst = 1'b1; ir = '0; mr = 1'b1; stop = 1'b0;
    add_i  = 32'h1A2B8000;
    neg_i  = 32'h8A800000;
    mul_i  = mk_ir(5'd15, 4'd3, 4'd7, 4'd0);
    div_i  = mk_ir(5'd16, 4'd1, 4'd2, 4'd0);
    sub_i  = mk_ir(5'd4, 4'd1, 4'd2, 4'd3);
    shra_i = mk_ir(5'd10, 4'd15, 4'd14, 4'd0);
    not_i  = mk_ir(5'd18, 4'd0, 4'd15, 4'd0);
    nop_i  = mk_ir(5'd26, 4'd0, 4'd0, 4'd0);
    ill_i  = mk_ir(5'd31, 4'd0, 4'd0, 4'd0);
    hlt_i  = mk_ir(5'd27, 4'd0, 4'd0, 4'd0);

    add_v("add_rst", add_i, e_zero(), 1'b1, 1'b0, 1'b1);
    add_fetch("add", add_i);
    add_v("add_e3", add_i, e_rout(5, 1'b1, 4'h0, 1'b0));
    add_v("add_e4", add_i, e_rout(7, 1'b0, 4'h2, 1'b1));
    add_v("add_e5", add_i, e_wb(4));
    add_fetch("neg", neg_i);
    add_v("neg_e3", neg_i, e_rout(0, 1'b0, 4'hC, 1'b1));
    add_v("neg_e4", neg_i, e_wb(5));
    add_fetch("mul", mul_i);
    add_v("mul_e3", mul_i, e_rout(3, 1'b1, 4'h0, 1'b0));
    add_v("mul_e4", mul_i, e_rout(7, 1'b0, 4'h4, 1'b1));
    add_v("mul_e5", mul_i, e_lo());
    add_v("mul_e6", mul_i, e_hi());
    add_fetch("div", div_i);
    add_v("div_e3", div_i, e_rout(1, 1'b1, 4'h0, 1'b0));
    add_v("div_e4", div_i, e_rout(2, 1'b0, 4'h6, 1'b1));
    add_v("div_e5", div_i, e_lo());
    add_v("div_e6", div_i, e_hi());
    add_fetch("sub", sub_i);
    add_v("sub_e3", sub_i, e_rout(2, 1'b1, 4'h0, 1'b0));
    add_v("sub_e4", sub_i, e_rout(3, 1'b0, 4'h3, 1'b1));
    add_v("sub_e5", sub_i, e_wb(1));
    add_fetch("shra", shra_i);
    add_v("shra_e3", shra_i, e_rout(14, 1'b1, 4'h0, 1'b0));
    add_v("shra_e4", shra_i, e_rout(0, 1'b0, 4'h8, 1'b1));
    add_v("shra_e5", shra_i, e_wb(15));
    add_fetch("not", not_i);
    add_v("not_e3", not_i, e_rout(15, 1'b0, 4'hD, 1'b1));
    add_v("not_e4", not_i, e_wb(0));
    add_fetch("nop", nop_i);
    add_v("nop_e3", nop_i, e_run());
    // Three stall cycles in F1; the short-timeout instance gives up after two.
    add_v("stall_f0", add_i, e_f0());
    add_v("stall_f1a", add_i, e_f1(1'b1), 1'b0, 1'b0, 1'b0, 1'b1, e_f1(1'b1));
    add_v("stall_f1b", add_i, e_f1(1'b0), 1'b0, 1'b0, 1'b0, 1'b1, e_f1(1'b0));
    add_v("stall_f1c", add_i, e_f1(1'b0), 1'b0, 1'b0, 1'b0, 1'b1, e_halt(2'b10));
    add_v("stall_f1d", add_i, e_f1(1'b0), 1'b1, 1'b0, 1'b0, 1'b1, e_halt(2'b10));
    add_v("stall_f2", add_i, e_f2(), 1'b1, 1'b0, 1'b0, 1'b1, e_halt(2'b10));
    add_v("stall_e3", add_i, e_rout(5, 1'b1, 4'h0, 1'b0));
    add_v("stall_e4", add_i, e_rout(7, 1'b0, 4'h2, 1'b1));
    add_v("stall_e5", add_i, e_wb(4));
    // Stop pulsed during fetch takes effect at the instruction boundary.
    add_v("stop_f0", add_i, e_f0());
    add_v("stop_f1", add_i, e_f1(1'b1), 1'b1, 1'b1);
    add_v("stop_f2", add_i, e_f2());
    add_v("stop_e3", add_i, e_rout(5, 1'b1, 4'h0, 1'b0));
    add_v("stop_e4", add_i, e_rout(7, 1'b0, 4'h2, 1'b1));
    add_v("stop_e5", add_i, e_wb(4));
    add_v("stop_halt_a", add_i, e_halt(2'b00));
    add_v("stop_halt_b", add_i, e_halt(2'b00));
    add_v("ill_rst", ill_i, e_zero(), 1'b1, 1'b0, 1'b1);
    add_fetch("ill", ill_i);
    add_v("ill_e3", ill_i, e_run());
    add_v("ill_halt_a", ill_i, e_halt(2'b01));
    add_v("ill_halt_b", ill_i, e_halt(2'b01));
    add_v("hlt_rst", hlt_i, e_zero(), 1'b1, 1'b0, 1'b1);
    add_fetch("hlt", hlt_i);
    add_v("hlt_e3", hlt_i, e_run());
    add_v("hlt_halt_a", hlt_i, e_halt(2'b00));
    add_v("hlt_halt_b", nop_i, e_halt(2'b00));
    // Reset mid-execute, then one more add to reach E4.
    add_v("mid_rst", add_i, e_zero(), 1'b1, 1'b0, 1'b1);
    add_fetch("mid", add_i);
    add_v("mid_e3", add_i, e_rout(5, 1'b1, 4'h0, 1'b0));

    @(negedge clk);
    foreach (tbl[i]) step(tbl[i]);

    // Now in E4 of the add: assert reset between edges.
    #1;
    check_now("mid_e4", e_rout(7, 1'b0, 4'h2, 1'b1));
    rst = 1'b1;
    #1;
    check_now("async_reset", e_zero());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_now("release_rst", e_zero());
    @(posedge clk);
    #1;
    check_now("release_f0", e_f0());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
